// File: rtl/mux8_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the mux8 round-robin arbiter.
// master = requester side, slave = arbiter side.
interface mux8_rr_arbiter_if;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;

  modport master (output req, input gnt, input sel, input busy);
  modport slave  (input req, output gnt, output sel, output busy);
endinterface

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving the select lines of a shared 8-to-1 mux.
// Grant tenure is capped at MAX_HOLD cycles; release re-arbitrates in the same edge.
module mux8_rr_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst,
  mux8_rr_arbiter_if.slave   bus
);
  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

  state_t     state_reg, state_next;
  logic [2:0] ptr_reg, ptr_next;
  logic [2:0] sel_reg, sel_next;
  logic [7:0] gnt_reg, gnt_next;
  logic       busy_reg, busy_next;
  logic [3:0] hold_cnt_reg, hold_cnt_next;

  logic       release_now;
  logic [2:0] search_base;
  logic [7:0] rot_req;
  logic       found;
  logic [2:0] offset;
  logic [2:0] winner;
  logic [7:0] winner_onehot;

  // sel_reg doubles as the current owner index while busy.
  assign release_now = (state_reg == GRANT) &&
                       (!bus.req[sel_reg] || hold_cnt_reg == HOLD_LIMIT);
  assign search_base = release_now ? sel_reg + 3'd1 : ptr_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rot
      assign rot_req[gi]       = bus.req[search_base + 3'(gi)];
      assign winner_onehot[gi] = (winner == 3'(gi));
    end
  endgenerate

  // Lowest offset in the rotated vector is the first requester after the pointer.
  always_comb begin
    found  = 1'b0;
    offset = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (rot_req[k]) begin
        found  = 1'b1;
        offset = 3'(k);
      end
    end
  end

  assign winner = search_base + offset;

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    sel_next      = sel_reg;
    gnt_next      = gnt_reg;
    busy_next     = busy_reg;
    hold_cnt_next = hold_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (found) begin
          state_next    = GRANT;
          gnt_next      = winner_onehot;
          sel_next      = winner;
          busy_next     = 1'b1;
          hold_cnt_next = 4'd1;
        end
      end
      GRANT: begin
        if (!release_now) begin
          hold_cnt_next = hold_cnt_reg + 4'd1;
        end else begin
          ptr_next = sel_reg + 3'd1;
          if (found) begin
            gnt_next      = winner_onehot;
            sel_next      = winner;
            hold_cnt_next = 4'd1;
          end else begin
            state_next    = IDLE;
            gnt_next      = 8'd0;
            busy_next     = 1'b0;
            hold_cnt_next = 4'd0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      ptr_reg      <= 3'd0;
      sel_reg      <= 3'd0;
      gnt_reg      <= 8'd0;
      busy_reg     <= 1'b0;
      hold_cnt_reg <= 4'd0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      sel_reg      <= sel_next;
      gnt_reg      <= gnt_next;
      busy_reg     <= busy_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  assign bus.gnt  = gnt_reg;
  assign bus.sel  = sel_reg;
  assign bus.busy = busy_reg;
endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
Round-robin arbiter that shares one 8-to-1 gate-level mux among 8 requesters.
- Grants one requester at a time and drives the mux select lines (s2 s1 s0) with that requester's index.
- Sits beside the mux in the ALU datapath; requester i's data is wired to mux input d(i).
- Limits grant tenure with a hold counter so no requester can starve the others.

Parameters:
- MAX_HOLD, 4, maximum consecutive cycles one grant may last; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  request vector; bit i high = requester i wants the mux.
- gnt  output 8  one-hot grant vector, registered; all zero when idle.
- sel  output 3  mux select index, registered; sel[0]->s0, sel[1]->s1, sel[2]->s2.
- busy output 1  high while any grant is active.

Behaviour:
- Reset (asynchronous, effective immediately, including mid-grant):
  - gnt=0, sel=0, busy=0, priority pointer ptr=0, hold_cnt=0, state=IDLE.
- Internal state:
  - ptr (3 bit): index where the priority search starts.
  - cur (3 bit): granted index; equals sel while busy.
  - hold_cnt (4 bit): cycles the current grant has lasted.
- Priority search: scan ptr, ptr+1, ... ptr+7 (mod 8) and pick the first index with req high.
- IDLE:
  - req==0: stay IDLE; gnt=0, busy=0, sel holds its last value (no datapath toggling).
  - req!=0: at the edge, gnt=onehot(winner), sel=winner, busy=1, hold_cnt=1, state=GRANT.
  - Latency: req sampled at edge N, grant visible after edge N (one cycle).
- GRANT, per edge:
  - Release condition: req[cur]==0, or hold_cnt==MAX_HOLD.
  - No release: hold gnt and sel; hold_cnt+1.
  - Release: ptr=cur+1 (mod 8), then re-arbitrate in the same edge using the updated ptr and the current req.
    - Winner found: new gnt and sel, hold_cnt=1, stay GRANT. This gives a back-to-back grant with no idle bubble.
    - No winner: gnt=0, busy=0, sel holds, state=IDLE.
  - Only cur requesting when MAX_HOLD expires: the search wraps back to cur, so it is regranted with hold_cnt=1.
  - Requests from other indices never preempt a grant before its release condition.
- Wrap-around: ptr goes 7 -> 0; index 7 expiring gives search order 0,1,...,7.
- MAX_HOLD=1: every grant lasts exactly one cycle, so all active requesters rotate each cycle.
- Invariants:
  - gnt is always zero or one-hot.
  - busy == |gnt.
  - While busy, gnt[sel]==1.
  - No combinational path from req to any output.

Test Plan:
- Reset: assert rst mid-grant (gnt=8'h04) -> gnt=0, sel=0, busy=0 immediately, without waiting for clk; after release, req=8'h01 -> gnt=8'h01 one edge later.
- Single requester, MAX_HOLD=4: req=8'h20 held -> gnt=8'h20, sel=5 for 4 cycles, regranted at the expiry edge with no bubble; drop req -> gnt=0 next edge, busy=0, sel stays 5.
- Rotation: req=8'hFF constant, MAX_HOLD=4 from reset -> grants 0,1,...,7,0, four cycles each; sel tracks the index.
- Wrap and skip: grant at index 6 expires with req=8'h41 -> next grant is index 0, not 6; sel=0.
- Early release: grant at index 2, other reqs 8'h90; drop req[2] after 2 cycles -> next edge gnt=8'h10 (index 4 is first after 3); hold_cnt restarts at 1.
- MAX_HOLD=1 with req=8'h81 -> gnt alternates 8'h01 and 8'h80 every cycle; busy stays 1 throughout.
